// File: rtl/feedback_scorer.sv
// feedback_scorer: multi-cycle Mastermind black/white scorer with win and game-over flags
module feedback_scorer #(
  parameter int NPEGS   = 4,
  parameter int NCOLORS = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] guess3,
  input  logic [2:0] guess2,
  input  logic [2:0] guess1,
  input  logic [2:0] guess0,
  input  logic [2:0] secret3,
  input  logic [2:0] secret2,
  input  logic [2:0] secret1,
  input  logic [2:0] secret0,
  input  logic       last_turn,
  output logic       busy,
  output logic       done,
  output logic [2:0] black,
  output logic [2:0] white,
  output logic       win,
  output logic       game_over
);
  typedef enum logic [1:0] {IDLE, EXACT, COLOR, REPORT} state_t;
  state_t state, state_nxt;
  logic [NPEGS-1:0][2:0] g_q, s_q;
  logic [NPEGS-1:0] g_used, s_used;
  logic [1:0] idx;
  logic [2:0] col, black_acc, white_acc, gc, sc, wmin;
  logic lt_q, hit;
  // next-state sequencing through the exact pass and the colour pass
  always_comb begin
    state_nxt = state == IDLE  ? (start ? EXACT : IDLE) :
                state == EXACT ? (idx == 2'd3 ? COLOR : EXACT) :
                state == COLOR ? (col == 3'(NCOLORS - 1) ? REPORT : COLOR) : IDLE;
  end
  // per-cycle match terms: exact hit at idx, and unused-peg counts of colour col
  always_comb begin
    hit = g_q[idx] == s_q[idx];
    gc = '0;
    sc = '0;
    for (int i = 0; i < NPEGS; i++) begin
      gc = gc + 3'(!g_used[i] && g_q[i] == col);
      sc = sc + 3'(!s_used[i] && s_q[i] == col);
    end
    wmin = gc < sc ? gc : sc;
  end
  // state register, operand capture, accumulators and result registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      g_q       <= '0;
      s_q       <= '0;
      g_used    <= '0;
      s_used    <= '0;
      idx       <= '0;
      col       <= '0;
      black_acc <= '0;
      white_acc <= '0;
      lt_q      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      black     <= '0;
      white     <= '0;
      win       <= 1'b0;
      game_over <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            g_q       <= {guess3, guess2, guess1, guess0};
            s_q       <= {secret3, secret2, secret1, secret0};
            lt_q      <= last_turn;
            g_used    <= '0;
            s_used    <= '0;
            black_acc <= '0;
            white_acc <= '0;
            idx       <= '0;
            busy      <= 1'b1;
          end
        end
        EXACT: begin
          if (hit) begin
            black_acc   <= black_acc + 3'd1;
            g_used[idx] <= 1'b1;
            s_used[idx] <= 1'b1;
          end
          idx <= idx + 2'd1;
          col <= '0;
        end
        COLOR: begin
          white_acc <= white_acc + wmin;
          col       <= col + 3'd1;
        end
        default: begin
          black     <= black_acc;
          white     <= white_acc;
          win       <= black_acc == 3'(NPEGS);
          game_over <= black_acc == 3'(NPEGS) || lt_q;
          done      <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_feedback_scorer.sv
// tb_feedback_scorer: directed checks of scoring results, latency, busy protection and reset
module tb_feedback_scorer;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, last_turn = 1'b0;
  logic [2:0] guess3 = '0, guess2 = '0, guess1 = '0, guess0 = '0;
  logic [2:0] secret3 = '0, secret2 = '0, secret1 = '0, secret0 = '0;
  logic busy, done, win, game_over;
  logic [2:0] black, white;
  int total = 0, bad = 0;

  feedback_scorer dut (
    .clk(clk), .reset(reset), .start(start),
    .guess3(guess3), .guess2(guess2), .guess1(guess1), .guess0(guess0),
    .secret3(secret3), .secret2(secret2), .secret1(secret1), .secret0(secret0),
    .last_turn(last_turn), .busy(busy), .done(done), .black(black), .white(white),
    .win(win), .game_over(game_over)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_ops(input logic [2:0] g3, g2, g1, g0, s3, s2, s1, s0, input logic lt);
    {guess3, guess2, guess1, guess0} = {g3, g2, g1, g0};
    {secret3, secret2, secret1, secret0} = {s3, s2, s1, s0};
    last_turn = lt;
  endtask

  task automatic wait_done(input string tag, output int n);
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (done) begin n = i; break; end
    end
    chk({tag, "_latency"}, n, 13);
  endtask

  task automatic check_res(input string tag, input int eb, ew, ewin, ego);
    chk({tag, "_black"}, black, eb);
    chk({tag, "_white"}, white, ew);
    chk({tag, "_win"}, win, ewin);
    chk({tag, "_game_over"}, game_over, ego);
    chk({tag, "_sum_le4"}, int'(black + white <= 3'd4), 1);
    chk({tag, "_win_nowhite"}, int'(!win || white == 3'd0), 1);
  endtask

  task automatic score(input string tag, input logic [2:0] g3, g2, g1, g0, s3, s2, s1, s0,
                       input logic lt, input int eb, ew, ewin, ego);
    int n;
    set_ops(g3, g2, g1, g0, s3, s2, s1, s0, lt);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, "_busy"}, busy, 1);
    wait_done(tag, n);
    chk({tag, "_busy_at_done"}, busy, 0);
    check_res(tag, eb, ew, ewin, ego);
    @(posedge clk); #1;
    chk({tag, "_done_width"}, done, 0);
  endtask

  initial begin
    int n, pulses;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    check_res("rst", 0, 0, 0, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    score("exact", 5, 3, 1, 7, 5, 3, 1, 7, 0, 4, 0, 1, 1);
    score("perm", 1, 2, 3, 4, 4, 3, 2, 1, 0, 0, 4, 0, 0);
    score("dup1", 1, 1, 2, 2, 1, 2, 1, 3, 0, 1, 2, 0, 0);
    score("dup2", 0, 0, 0, 0, 0, 1, 2, 3, 0, 1, 0, 0, 0);

    // busy protection: restart attempt and operand change at E5
    set_ops(1, 1, 2, 2, 1, 2, 1, 3, 0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    set_ops(5, 3, 1, 7, 5, 3, 1, 7, 1);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    pulses = 0;
    n = 0;
    for (int i = 6; i <= 40; i++) begin
      @(posedge clk); #1;
      if (done) begin
        pulses++;
        if (n == 0) n = i;
      end
    end
    chk("busy_latency", n, 13);
    chk("busy_pulses", pulses, 1);
    check_res("busy", 1, 2, 0, 0);

    // reset mid-operation at E7
    set_ops(1, 2, 3, 4, 4, 3, 2, 1, 0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    check_res("midrst", 0, 0, 0, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done || busy) pulses++;
    end
    chk("midrst_quiet", pulses, 0);
    score("after_rst", 1, 2, 3, 4, 4, 3, 2, 1, 0, 0, 4, 0, 0);

    // final turn lose, then outputs hold while idle
    score("last", 2, 2, 2, 2, 2, 2, 2, 6, 1, 3, 0, 0, 1);
    set_ops(5, 3, 1, 7, 5, 3, 1, 7, 0);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done || busy || black != 3'd3 || white != 3'd0 || win || !game_over) pulses++;
    end
    chk("hold_changes", pulses, 0);
    check_res("hold", 3, 0, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
